pcie_apb_master: RTL and testbench
==================================

PCIE_APB_MASTER -- requirements
Module: pcie_apb_master

Interface
REQ-001 SHALL have parameter: timeout_cycles, 1024, ACCESS-phase cycles without PREADY before abort (effective only with PCIE_APB_MASTER_TIMEOUT_EN).
REQ-002 SHALL have port: i_clk  in  1  clock, all logic rising-edge.
REQ-003 SHALL have port: i_nrst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: i_req_valid  in  1  request valid from PCIe DMA side.
REQ-005 SHALL have port: o_req_ready  out  1  request accepted when high with i_req_valid.
REQ-006 SHALL have port: i_req_addr  in  32  byte address.
REQ-007 SHALL have port: i_req_write  in  1  1=write, 0=read.
REQ-008 SHALL have port: i_req_wdata  in  32  write data.
REQ-009 SHALL have port: i_req_wstrb  in  4  byte strobes, used for writes only.
REQ-010 SHALL have port: o_resp_valid  out  1  response valid.
REQ-011 SHALL have port: i_resp_ready  in  1  response consumed when high with o_resp_valid.
REQ-012 SHALL have port: o_resp_rdata  out  32  read data (0 for writes).
REQ-013 SHALL have port: o_resp_err  out  1  PSLVERR or timeout.
REQ-014 SHALL have port: o_apbo  out  types_amba_pkg::apb_in_type  APB request to slave (paddr, pprot, pselx, penable, pwrite, pwdata, pstrb).
REQ-015 SHALL have port: i_apbi  in  types_amba_pkg::apb_out_type  APB response from slave (prdata, pready, pslverr).
REQ-016 SHALL have port: o_busy  out  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; all outputs driven from registers.
REQ-018 SHALL hold o_req_ready=1 only in IDLE; on i_req_valid&o_req_ready latch addr/write/wdata/wstrb, go to SETUP next cycle.
REQ-019 SHALL in SETUP drive pselx=1, penable=0, latched paddr/pwrite/pwdata, pstrb=wstrb for write or 4'h0 for read, pprot=3'b000; go to ACCESS next cycle.
REQ-020 SHALL in ACCESS drive pselx=1, penable=1, hold all APB signals stable until pready=1.
REQ-021 SHALL on ACCESS with pready=1 capture prdata (reads; 0 for writes) and pslverr into response registers, deassert pselx/penable next cycle, go to RESP.
REQ-022 SHALL in RESP hold o_resp_valid=1 with stable rdata/err until i_resp_ready=1, then go to IDLE; o_req_ready=1 in that following cycle.
REQ-023 SHALL give minimum latency acceptance->o_resp_valid of 3 cycles (zero-wait slave); each PREADY wait state adds one cycle.
REQ-024 SHALL sustain at most one outstanding transaction; back-to-back minimum period 4 cycles with i_resp_ready tied high.
REQ-025 SHALL ignore i_req_valid outside IDLE and ignore i_apbi outside ACCESS.
REQ-026 SHALL drive pselx=0, penable=0 in IDLE and RESP; paddr/pwdata values there are don't-care but SHALL not toggle outside a transfer.

Reset
REQ-027 SHALL on i_nrst=0 asynchronously enter IDLE and clear: o_req_ready=0, o_resp_valid=0, o_resp_rdata=0, o_resp_err=0, o_busy=0, pselx=0, penable=0, paddr=0, pwdata=0, pstrb=0, pwrite=0, timeout counter=0.
REQ-028 SHALL assert o_req_ready=1 on the first clock edge after i_nrst release.
REQ-029 SHALL on reset mid-transfer (SETUP/ACCESS/RESP) abandon it, deassert pselx/penable immediately and emit no response.

Configuration
REQ-030 SHALL, with PCIE_APB_MASTER_TIMEOUT_EN defined, count ACCESS cycles with pready=0 from 0; on reaching timeout_cycles-1 without pready, end the transfer (pselx=0), go to RESP with o_resp_err=1, o_resp_rdata=0; counter clears on entering SETUP.
REQ-031 SHALL, without PCIE_APB_MASTER_TIMEOUT_EN, omit the counter and wait in ACCESS indefinitely for pready.

Verification
REQ-032 Write addr=0x0000_0040, wdata=0xDEAD_BEEF, wstrb=0xF, pready=1 immediately -> SETUP then ACCESS, pstrb=0xF, o_resp_valid 3 cycles after accept, err=0, rdata=0.
REQ-033 Read addr=0x0000_0008, slave 3 wait states then prdata=0x0000_0005 -> penable high 4 cycles, paddr stable, rdata=0x5, pstrb=0, latency 6 cycles.
REQ-034 Read with pslverr=1 and prdata=0x1234 -> o_resp_err=1, rdata=0x1234, FSM returns to IDLE after i_resp_ready.
REQ-035 i_resp_ready low 5 cycles -> o_resp_valid/rdata/err held, o_req_ready=0, new i_req_valid ignored until handshake.
REQ-036 Timeout build, timeout_cycles=16, pready stuck 0 -> pselx drops after 16 ACCESS cycles, err=1, rdata=0; non-timeout build -> still in ACCESS after 1000 cycles.
REQ-037 i_nrst pulsed low during ACCESS -> pselx/penable 0 same cycle, no o_resp_valid, o_req_ready=1 one edge after release.

Source files
------------

// File: rtl/pcie_apb_master.sv
// -----------------------------------------------------------------------------
// pcie_apb_master
//
// Bridges single request/response transactions from the PCIe DMA side onto an
// APB master port. One transaction is outstanding at a time. The sequence is
// IDLE -> SETUP -> ACCESS (extended by PREADY wait states) -> RESP -> IDLE.
// Every output comes straight from a register.
//
// Optional feature (macro PCIE_APB_MASTER_TIMEOUT_EN):
//   When defined, an ACCESS phase that sees no PREADY for timeout_cycles
//   cycles is abandoned. It completes with o_resp_err=1 and o_resp_rdata=0.
//   When not defined, ACCESS waits for PREADY indefinitely.
//
// Parameters:
//   timeout_cycles  ACCESS cycles without PREADY before abort (timeout build)
//
// Ports:
//   i_clk          clock, rising edge
//   i_nrst         asynchronous active-low reset
//   i_req_valid    request valid            o_req_ready   request accepted (IDLE)
//   i_req_addr     byte address             i_req_write   1=write, 0=read
//   i_req_wdata    write data               i_req_wstrb   byte strobes (writes)
//   o_resp_valid   response valid           i_resp_ready  response consumed
//   o_resp_rdata   read data (0 for writes) o_resp_err    PSLVERR or timeout
//   o_apbo         APB request to slave     i_apbi        APB response from slave
//   o_busy         high in any state other than IDLE
// -----------------------------------------------------------------------------

package types_amba_pkg;

    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  pprot;
        logic        pselx;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb_in_type;

    typedef struct packed {
        logic [31:0] prdata;
        logic        pready;
        logic        pslverr;
    } apb_out_type;

endpackage

module pcie_apb_master #(
    parameter int unsigned timeout_cycles = 1024
) (
    input  logic                       i_clk,
    input  logic                       i_nrst,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic [31:0]                i_req_addr,
    input  logic                       i_req_write,
    input  logic [31:0]                i_req_wdata,
    input  logic [3:0]                 i_req_wstrb,
    output logic                       o_resp_valid,
    input  logic                       i_resp_ready,
    output logic [31:0]                o_resp_rdata,
    output logic                       o_resp_err,
    output types_amba_pkg::apb_in_type o_apbo,
    input  types_amba_pkg::apb_out_type i_apbi,
    output logic                       o_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state, state_next;

    logic        req_ready, req_ready_next;
    logic        resp_valid, resp_valid_next;
    logic [31:0] resp_rdata, resp_rdata_next;
    logic        resp_err, resp_err_next;
    logic        busy, busy_next;

    logic        psel, psel_next;
    logic        penable, penable_next;
    logic [31:0] paddr, paddr_next;
    logic        pwrite, pwrite_next;
    logic [31:0] pwdata, pwdata_next;
    logic [3:0]  pstrb, pstrb_next;

`ifdef PCIE_APB_MASTER_TIMEOUT_EN
    localparam int unsigned     CNT_W    = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout_cycles - 1);

    logic [CNT_W-1:0] cnt, cnt_next;
`else
    localparam int unsigned unused_timeout_cycles = timeout_cycles;
`endif

    // -------------------------------------------------------------------------
    // Next-state and next-register computation
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state;
        paddr_next      = paddr;
        pwrite_next     = pwrite;
        pwdata_next     = pwdata;
        pstrb_next      = pstrb;
        resp_rdata_next = resp_rdata;
        resp_err_next   = resp_err;
`ifdef PCIE_APB_MASTER_TIMEOUT_EN
        cnt_next        = cnt;
`endif

        case (state)
            IDLE: begin
                // req_ready (the register) gates acceptance so nothing is taken
                // in the cycle right after reset release.
                if (i_req_valid && req_ready) begin
                    state_next  = SETUP;
                    paddr_next  = i_req_addr;
                    pwrite_next = i_req_write;
                    pwdata_next = i_req_wdata;
                    pstrb_next  = i_req_write ? i_req_wstrb : 4'h0;
`ifdef PCIE_APB_MASTER_TIMEOUT_EN
                    cnt_next    = '0;
`endif
                end
            end

            SETUP: begin
                state_next = ACCESS;
            end

            ACCESS: begin
                if (i_apbi.pready) begin
                    state_next      = RESP;
                    resp_rdata_next = pwrite ? 32'h0 : i_apbi.prdata;
                    resp_err_next   = i_apbi.pslverr;
                end
`ifdef PCIE_APB_MASTER_TIMEOUT_EN
                else if (cnt == CNT_LAST) begin
                    state_next      = RESP;
                    resp_rdata_next = '0;
                    resp_err_next   = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
`endif
            end

            RESP: begin
                if (i_resp_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs are registered versions of the decode of the next state.
        req_ready_next  = (state_next == IDLE);
        busy_next       = (state_next != IDLE);
        psel_next       = (state_next == SETUP) || (state_next == ACCESS);
        penable_next    = (state_next == ACCESS);
        resp_valid_next = (state_next == RESP);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            paddr      <= '0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            pstrb      <= '0;
`ifdef PCIE_APB_MASTER_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            state      <= state_next;
            req_ready  <= req_ready_next;
            resp_valid <= resp_valid_next;
            resp_rdata <= resp_rdata_next;
            resp_err   <= resp_err_next;
            busy       <= busy_next;
            psel       <= psel_next;
            penable    <= penable_next;
            paddr      <= paddr_next;
            pwrite     <= pwrite_next;
            pwdata     <= pwdata_next;
            pstrb      <= pstrb_next;
`ifdef PCIE_APB_MASTER_TIMEOUT_EN
            cnt        <= cnt_next;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Output mapping
    // -------------------------------------------------------------------------
    assign o_req_ready    = req_ready;
    assign o_resp_valid   = resp_valid;
    assign o_resp_rdata   = resp_rdata;
    assign o_resp_err     = resp_err;
    assign o_busy         = busy;

    assign o_apbo.paddr   = paddr;
    assign o_apbo.pprot   = 3'b000;
    assign o_apbo.pselx   = psel;
    assign o_apbo.penable = penable;
    assign o_apbo.pwrite  = pwrite;
    assign o_apbo.pwdata  = pwdata;
    assign o_apbo.pstrb   = pstrb;

endmodule

// File: tb/tb_pcie_apb_master.sv
// -----------------------------------------------------------------------------
// tb_pcie_apb_master
//
// Self-checking bench for pcie_apb_master. A behavioural APB slave is driven
// inline. Expected values come from the transaction description: APB fields
// seen in SETUP/ACCESS, ACCESS length = waits+1, response at cycle waits+3
// after acceptance, rdata = write ? 0 : prdata, err = pslverr. The timeout
// scenario follows PCIE_APB_MASTER_TIMEOUT_EN as the DUT does.
// -----------------------------------------------------------------------------

module tb_pcie_apb_master;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        nrst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    types_amba_pkg::apb_in_type  apbo;
    types_amba_pkg::apb_out_type apbi;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pcie_apb_master #(.timeout_cycles(TO)) dut (
        .i_clk        (clk),
        .i_nrst       (nrst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_addr   (req_addr),
        .i_req_write  (req_write),
        .i_req_wdata  (req_wdata),
        .i_req_wstrb  (req_wstrb),
        .o_resp_valid (resp_valid),
        .i_resp_ready (resp_ready),
        .o_resp_rdata (resp_rdata),
        .o_resp_err   (resp_err),
        .o_apbo       (apbo),
        .i_apbi       (apbi),
        .o_busy       (busy)
    );

    function automatic types_amba_pkg::apb_out_type junk_apbi(input logic rdy);
        types_amba_pkg::apb_out_type a;
        a.prdata  = $urandom;
        a.pready  = rdy;
        a.pslverr = 1'($urandom);
        return a;
    endfunction

    // One full transaction with the slave inserting 'waits' wait states and the
    // requester holding i_resp_ready low for 'hold' cycles.
    task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                           input logic [3:0] ws, input int waits, input logic [31:0] rd,
                           input logic err, input int hold);
        logic [31:0] exp_rdata;
        logic [3:0]  exp_strb;
        exp_rdata = wr ? 32'h0 : rd;
        exp_strb  = wr ? ws : 4'h0;

        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL txn_idle_ready: got %b expected 1", req_ready);
        end
        req_valid = 1'b1;
        req_addr  = addr;
        req_write = wr;
        req_wdata = wd;
        req_wstrb = ws;
        apbi      = junk_apbi(1'($urandom));

        // SETUP
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
        req_write = 1'($urandom);
        checks++;
        if ({apbo.pselx, apbo.penable, apbo.pprot, busy, req_ready, resp_valid} !== 8'b10_000_100) begin
            failures++;
            $display("FAIL setup_ctrl: got %b expected 10000100",
                     {apbo.pselx, apbo.penable, apbo.pprot, busy, req_ready, resp_valid});
        end
        checks++;
        if ({apbo.paddr, apbo.pwrite, apbo.pwdata, apbo.pstrb} !== {addr, wr, wd, exp_strb}) begin
            failures++;
            $display("FAIL setup_fields: got %h/%b/%h/%h expected %h/%b/%h/%h",
                     apbo.paddr, apbo.pwrite, apbo.pwdata, apbo.pstrb, addr, wr, wd, exp_strb);
        end
        apbi = junk_apbi(1'b1);

        // ACCESS, waits+1 cycles
        for (int k = 0; k <= waits; k++) begin
            @(negedge clk);
            checks++;
            if ({apbo.pselx, apbo.penable, resp_valid} !== 3'b110 ||
                {apbo.paddr, apbo.pwrite, apbo.pwdata, apbo.pstrb} !== {addr, wr, wd, exp_strb}) begin
                failures++;
                $display("FAIL access_cycle%0d: got sel/en/rv=%b paddr=%h pstrb=%h expected 110 %h %h",
                         k, {apbo.pselx, apbo.penable, resp_valid}, apbo.paddr, apbo.pstrb, addr, exp_strb);
            end
            if (k == waits) begin
                apbi.prdata  = rd;
                apbi.pready  = 1'b1;
                apbi.pslverr = err;
            end else begin
                apbi = junk_apbi(1'b0);
            end
        end

        // RESP
        @(negedge clk);
        apbi = junk_apbi(1'($urandom));
        checks++;
        if ({resp_valid, apbo.pselx, apbo.penable, busy, req_ready} !== 5'b10010 ||
            {resp_rdata, resp_err} !== {exp_rdata, err}) begin
            failures++;
            $display("FAIL resp: got rv/sel/en/busy/rdy=%b rdata=%h err=%b expected 10010 %h %b",
                     {resp_valid, apbo.pselx, apbo.penable, busy, req_ready}, resp_rdata, resp_err, exp_rdata, err);
        end

        for (int h = 0; h < hold; h++) begin
            resp_ready = 1'b0;
            req_valid  = 1'b1;
            req_addr   = $urandom;
            apbi       = junk_apbi(1'b1);
            @(negedge clk);
            checks++;
            if ({resp_valid, req_ready, apbo.pselx} !== 3'b100 ||
                {resp_rdata, resp_err} !== {exp_rdata, err}) begin
                failures++;
                $display("FAIL resp_hold%0d: got rv/rdy/sel=%b rdata=%h err=%b expected 100 %h %b",
                         h, {resp_valid, req_ready, apbo.pselx}, resp_rdata, resp_err, exp_rdata, err);
            end
        end

        resp_ready = 1'b1;
        req_valid  = 1'b0;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if ({resp_valid, busy, req_ready, apbo.pselx, apbo.penable} !== 5'b00100 ||
            {apbo.paddr, apbo.pwdata} !== {addr, wd}) begin
            failures++;
            $display("FAIL back_to_idle: got rv/busy/rdy/sel/en=%b paddr=%h expected 00100 %h",
                     {resp_valid, busy, req_ready, apbo.pselx, apbo.penable}, apbo.paddr, addr);
        end
    endtask

    task automatic test_reset();
        nrst       = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_write  = 1'b0;
        req_wdata  = '0;
        req_wstrb  = '0;
        resp_ready = 1'b0;
        apbi       = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_err, busy, apbo.pselx, apbo.penable, apbo.pwrite} !== 7'b0 ||
            {resp_rdata, apbo.paddr, apbo.pwdata, apbo.pstrb, apbo.pprot} !== '0) begin
            failures++;
            $display("FAIL reset_values: got ctrl=%b rdata=%h paddr=%h pwdata=%h pstrb=%h expected all zero",
                     {req_ready, resp_valid, resp_err, busy, apbo.pselx, apbo.penable, apbo.pwrite},
                     resp_rdata, apbo.paddr, apbo.pwdata, apbo.pstrb);
        end
        nrst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_ready_early: got %b expected 0", req_ready);
        end
        @(negedge clk);
        checks++;
        if ({req_ready, busy} !== 2'b10) begin
            failures++;
            $display("FAIL reset_first_edge: got rdy/busy=%b expected 10", {req_ready, busy});
        end
    endtask

    task automatic test_write_zero_wait();
        run_txn(32'h0000_0040, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 32'hFFFF_FFFF, 1'b0, 0);
    endtask

    task automatic test_read_wait_states();
        run_txn(32'h0000_0008, 1'b0, 32'h1111_2222, 4'hA, 3, 32'h0000_0005, 1'b0, 0);
    endtask

    task automatic test_read_slverr();
        run_txn(32'h0000_0100, 1'b0, 32'h0, 4'h0, 1, 32'h0000_1234, 1'b1, 1);
    endtask

    task automatic test_resp_backpressure();
        run_txn(32'h0000_0200, 1'b0, 32'h0, 4'h3, 2, 32'hCAFE_F00D, 1'b0, 5);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            run_txn($urandom, 1'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 4)),
                    $urandom, 1'($urandom), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_back_to_back();
        bit acc[32];
        bit rv[32];
        int n_acc;
        n_acc = 0;
        @(negedge clk);
        req_valid    = 1'b1;
        req_write    = 1'b1;
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_wstrb    = 4'hF;
        resp_ready   = 1'b1;
        apbi.prdata  = $urandom;
        apbi.pready  = 1'b1;
        apbi.pslverr = 1'b0;
        for (int c = 0; c < 32; c++) begin
            acc[c] = req_ready;
            rv[c]  = resp_valid;
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int c = 0; c < 32; c++) begin
            if (acc[c]) begin
                n_acc++;
                if (c + 4 < 32) begin
                    checks++;
                    if ({acc[c+1], acc[c+2], acc[c+3], acc[c+4], rv[c+3]} !== 5'b00011) begin
                        failures++;
                        $display("FAIL b2b_period_at%0d: got acc1..4,rv3=%b expected 00011",
                                 c, {acc[c+1], acc[c+2], acc[c+3], acc[c+4], rv[c+3]});
                    end
                end
            end
        end
        checks++;
        if (n_acc != 8) begin
            failures++;
            $display("FAIL b2b_count: got %0d expected 8", n_acc);
        end
        for (int i = 0; i < 10 && busy; i++) @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if ({busy, req_ready} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_drain: got busy/rdy=%b expected 01", {busy, req_ready});
        end
    endtask

    task automatic test_timeout();
        int  n_access;
        bool_t_dummy: begin end
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0300;
        apbi      = junk_apbi(1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        apbi      = junk_apbi(1'b0);
`ifdef PCIE_APB_MASTER_TIMEOUT_EN
        n_access = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            apbi = junk_apbi(1'b0);
            if (apbo.pselx && apbo.penable) n_access++;
            else break;
        end
        checks++;
        if (n_access != int'(TO)) begin
            failures++;
            $display("FAIL timeout_access_len: got %0d expected %0d", n_access, TO);
        end
        checks++;
        if ({resp_valid, resp_err, apbo.pselx, resp_rdata} !== {3'b110, 32'h0}) begin
            failures++;
            $display("FAIL timeout_resp: got rv/err/sel=%b rdata=%h expected 110 00000000",
                     {resp_valid, resp_err, apbo.pselx}, resp_rdata);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if ({req_ready, busy} !== 2'b10) begin
            failures++;
            $display("FAIL timeout_idle: got rdy/busy=%b expected 10", {req_ready, busy});
        end
`else
        n_access = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            apbi = junk_apbi(1'b0);
            if (apbo.pselx && apbo.penable && !resp_valid) n_access++;
        end
        checks++;
        if (n_access != 1000) begin
            failures++;
            $display("FAIL no_timeout_wait: got %0d ACCESS cycles expected 1000", n_access);
        end
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid_transfer();
        int saw_resp;
        saw_resp = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0400;
        req_wdata = 32'h5555_AAAA;
        req_wstrb = 4'hF;
        apbi      = junk_apbi(1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({apbo.pselx, apbo.penable} !== 2'b11) begin
            failures++;
            $display("FAIL midreset_in_access: got sel/en=%b expected 11", {apbo.pselx, apbo.penable});
        end
        #2;
        nrst = 1'b0;
        #1;
        checks++;
        if ({apbo.pselx, apbo.penable, resp_valid, busy, req_ready} !== 5'b0 || apbo.paddr !== 32'h0) begin
            failures++;
            $display("FAIL midreset_async: got sel/en/rv/busy/rdy=%b paddr=%h expected 00000 00000000",
                     {apbo.pselx, apbo.penable, resp_valid, busy, req_ready}, apbo.paddr);
        end
        apbi = junk_apbi(1'b1);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        checks++;
        if ({req_ready, resp_valid} !== 2'b00) begin
            failures++;
            $display("FAIL midreset_release: got rdy/rv=%b expected 00", {req_ready, resp_valid});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) saw_resp++;
        end
        checks++;
        if ({req_ready, apbo.pselx, busy} !== 3'b100 || saw_resp != 0) begin
            failures++;
            $display("FAIL midreset_after: got rdy/sel/busy=%b responses=%0d expected 100 0",
                     {req_ready, apbo.pselx, busy}, saw_resp);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait_states();
        test_read_slverr();
        test_resp_backpressure();
        test_random();
        test_back_to_back();
        test_timeout();
        test_reset_mid_transfer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
